// File: rtl/alu_pkg.sv
// Shared alucontrol encodings and FSM states for the multi-cycle ALU.
// DIVU is only a legal multi-cycle op when ALU_MC_DIV_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULTU = 4'b1000,
    OP_DIVU  = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_NOR   = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and, with ALU_MC_DIV_EN, restoring
// divide; one iteration per step, hi/lo committed on the last iteration.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    cnt;

`ifdef ALU_MC_DIV_EN
  logic             is_div;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
`else
  logic             unused_div;
  assign unused_div = op_div;
`endif

  assign last = (cnt == CW'(WIDTH - 1));

  // acc/q form one 2*WIDTH shift register: {acc,q} is the partial product
  // for multiply, {remainder,dividend/quotient} for divide.
  always_comb begin
    sum   = {1'b0, acc} + (q[0] ? {1'b0, opb} : '0);
    acc_n = sum[WIDTH:1];
    q_n   = {sum[0], q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    shifted = {acc, q[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - opb;
    if (is_div) begin
      if (shifted >= {1'b0, opb}) begin
        acc_n = diff;
        q_n   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted[WIDTH-1:0];
        q_n   = {q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      q   <= '0;
      opb <= '0;
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
`ifdef ALU_MC_DIV_EN
      is_div <= 1'b0;
`endif
    end else if (load) begin
      acc <= '0;
      q   <= a;
      opb <= b;
      cnt <= '0;
`ifdef ALU_MC_DIV_EN
      is_div <= op_div;
`endif
    end else if (step) begin
      acc <= acc_n;
      q   <= q_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        hi <= acc_n;
        lo <= q_n;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Combinational single-cycle ALU plus IDLE/RUN/DONE control for MULTU/DIVU.
// DIVU is compiled in only when ALU_MC_DIV_EN is defined.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_e           state, state_n;
  logic             load, step, last;
  logic             is_mul, is_div;
  logic [WIDTH-1:0] bb, sum;
  logic             ovf, slt;

  // Legacy 3-bit ALU: bit 2 inverts B and supplies carry-in, bits 1:0 select.
  always_comb begin
    bb  = alucontrol[2] ? ~srcb : srcb;
    sum = srca + bb + {{(WIDTH-1){1'b0}}, alucontrol[2]};
    ovf = (srca[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
    slt = sum[WIDTH-1] ^ ovf;
    aluout = '0;
    if (!alucontrol[3]) begin
      case (alucontrol[1:0])
        2'b00:   aluout = srca & bb;
        2'b01:   aluout = srca | bb;
        2'b10:   aluout = sum;
        default: aluout = {{(WIDTH-1){1'b0}}, slt};
      endcase
    end else begin
      case (alucontrol)
        OP_SLTU: aluout = {{(WIDTH-1){1'b0}}, (srca < srcb)};
        OP_NOR:  aluout = ~(srca | srcb);
        default: aluout = '0;
      endcase
    end
  end

  assign zero   = (aluout == '0);
  assign is_mul = (alucontrol == OP_MULTU);
`ifdef ALU_MC_DIV_EN
  assign is_div = (alucontrol == OP_DIVU);
`else
  assign is_div = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (is_mul || is_div)) begin
          load    = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .op_div (is_div),
    .a      (srca),
    .b      (srcb),
    .last   (last),
    .hi     (hi),
    .lo     (lo)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH = 32); DIVU vectors depend on ALU_MC_DIV_EN.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] srca, srcb;
  logic [3:0]  alucontrol;
  logic [31:0] aluout, hi, lo;
  logic        zero, busy, done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned done_seen;

  alu_mc #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .aluout     (aluout),
    .zero       (zero),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic comb(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_out, input logic exp_zero);
    alucontrol = op;
    srca = a;
    srcb = b;
    #1;
    check(tag, aluout, exp_out);
    check({tag, "_zero"}, zero, exp_zero);
  endtask

  // Drive start for one cycle (cycle 0) and advance into cycle 1.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    alucontrol = op;
    srca = a;
    srcb = b;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    srca = '0;
    srcb = '0;
    alucontrol = OP_AND;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b0;
    tick();

    comb("add", OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    comb("sub_eq", OP_SUB, 32'd3, 32'd3, 32'd0, 1'b1);
    comb("sub_neg", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    comb("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    comb("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    comb("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    comb("slt_ovf", OP_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
    comb("slt_ovf2", OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
    comb("nor", OP_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    comb("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    comb("or", OP_OR, 32'hF0F0_F0F0, 32'h0F00_0F00, 32'hFFF0_FFF0, 1'b0);
    comb("illegal", 4'b1111, 32'h1234_5678, 32'h1, 32'd0, 1'b1);
    comb("multu_aluout", OP_MULTU, 32'h5, 32'h6, 32'd0, 1'b1);

    // Start with a single-cycle code is ignored.
    launch(OP_ADD, 32'd1, 32'd2);
    check("start_add_ignored", busy, 1'b0);

    // MULTU timing: start in cycle 0, busy 1..32, done 33.
    tick();
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("mul_busy_c1", busy, 1'b1);
    check("mul_done_c1", done, 1'b0);
    alucontrol = OP_ADD;
    srca = 32'd40;
    srcb = 32'd2;
    #1;
    check("add_during_run", aluout, 32'd42);
    repeat (31) tick();
    check("mul_busy_c32", busy, 1'b1);
    check("mul_done_c32", done, 1'b0);
    check("mul_hi_c32_hold", hi, 32'h0);
    tick();
    check("mul_done_c33", done, 1'b1);
    check("mul_busy_c33", busy, 1'b0);
    check("mul_hi", hi, 32'h1);
    check("mul_lo", lo, 32'hFFFF_FFFE);
    tick();
    check("mul_done_c34", done, 1'b0);
    check("mul_hi_hold", hi, 32'h1);
    check("mul_lo_hold", lo, 32'hFFFF_FFFE);

    // Second start during RUN and during DONE is ignored.
    launch(OP_MULTU, 32'd3, 32'd5);
    repeat (4) tick();
    launch(OP_MULTU, 32'd7, 32'd7);
    repeat (27) tick();
    check("rerun_done_c33", done, 1'b1);
    check("rerun_lo", lo, 32'd15);
    check("rerun_hi", hi, 32'd0);
    launch(OP_MULTU, 32'd9, 32'd9);
    check("start_in_done_ignored", busy, 1'b0);
    check("rerun_lo_hold", lo, 32'd15);

    // Reset at cycle 10 of RUN aborts with hi/lo cleared and no done.
    tick();
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (9) tick();
    check("abort_busy_c10", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    done_seen = 0;
    repeat (30) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    // Reset wins over start in the same cycle.
    reset = 1'b1;
    launch(OP_MULTU, 32'd2, 32'd3);
    reset = 1'b0;
    check("reset_over_start", busy, 1'b0);
    tick();
    check("reset_over_start_c2", busy, 1'b0);

`ifdef ALU_MC_DIV_EN
    launch(OP_DIVU, 32'd100, 32'd7);
    check("div_busy", busy, 1'b1);
    repeat (32) tick();
    check("div_done", done, 1'b1);
    check("div_lo", lo, 32'd14);
    check("div_hi", hi, 32'd2);
    tick();
    launch(OP_DIVU, 32'd9, 32'd0);
    repeat (32) tick();
    check("div0_done", done, 1'b1);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd9);
    tick();
`else
    launch(OP_DIVU, 32'd100, 32'd7);
    check("divu_start_ignored", busy, 1'b0);
    comb("divu_aluout", OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b1);
`endif

    // MULTU still works after the abort.
    launch(OP_MULTU, 32'h1234_5678, 32'h0000_0010);
    repeat (32) tick();
    check("mul2_done", done, 1'b1);
    check("mul2_hi", hi, 32'h1);
    check("mul2_lo", lo, 32'h2345_6780);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  launch multi-cycle op; sampled only in IDLE.
REQ-005 SHALL have port srca  input  WIDTH  operand A.
REQ-006 SHALL have port srcb  input  WIDTH  operand B.
REQ-007 SHALL have port alucontrol  input  4  op code, encoded per REQ-013.
REQ-008 SHALL have port aluout  output  WIDTH  combinational single-cycle result.
REQ-009 SHALL have port zero  output  1  high when aluout == 0.
REQ-010 SHALL have port hi  output  WIDTH  registered upper product or remainder.
REQ-011 SHALL have port lo  output  WIDTH  registered lower product or quotient.
REQ-012 SHALL have ports busy and done, each output 1: op in progress; one-cycle completion pulse.

Function
REQ-013 Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1010 SLTU, 1011 NOR, 1000 MULTU, 1001 DIVU; any other code gives aluout = 0.
REQ-014 With alucontrol[3] = 0, aluout SHALL equal the 3-bit legacy ALU result (bit 2 inverts B, plus carry-in).
REQ-015 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT/SLTU SHALL zero-extend a 1-bit result to WIDTH.
REQ-016 Single-cycle ops SHALL be purely combinational and independent of start/busy.
REQ-017 States: IDLE, RUN, DONE.
REQ-018 IDLE -> RUN when start = 1 and code is MULTU or DIVU; operands and op SHALL latch at that edge.
REQ-019 Start with any other code SHALL be ignored.
REQ-020 RUN SHALL last exactly WIDTH cycles, one shift-add or restoring-subtract iteration per cycle; busy = 1 throughout RUN.
REQ-021 RUN -> DONE after iteration WIDTH: hi/lo SHALL update at that edge and done = 1 for one cycle.
REQ-022 DONE -> IDLE unconditionally; start latency to done is WIDTH+1 cycles.
REQ-023 start during RUN or DONE SHALL be ignored; inputs SHALL not affect an op in flight.
REQ-024 MULTU: {hi,lo} = srca*srcb unsigned, 2*WIDTH bits.
REQ-025 DIVU: lo = quotient, hi = remainder.
REQ-026 DIVU by zero SHALL give lo = all-ones and hi = srca with normal latency.
REQ-027 hi/lo SHALL hold their last value until the next done.

Reset
REQ-028 reset SHALL force IDLE, busy = 0, done = 0, hi = 0, lo = 0 on the next clk edge.
REQ-029 reset during RUN SHALL abort the op without updating hi/lo beyond REQ-028.
REQ-030 reset SHALL take priority over start in the same cycle.

Configuration
REQ-031 Macro ALU_MC_DIV_EN SHALL compile in the DIVU datapath.
REQ-032 Without ALU_MC_DIV_EN, DIVU SHALL be treated as an illegal code: start ignored, aluout = 0; MULTU is unaffected.

Structure
REQ-033 Package alu_pkg SHALL hold the alucontrol code localparams/enum and the FSM state enum.
REQ-034 Sub-module alu_muldiv SHALL hold the iterative multiply/divide datapath and counter; alu_mc SHALL hold the combinational ops and the FSM.

Verification (WIDTH = 32)
REQ-035 ADD 5 + 7 -> aluout = 12, zero = 0; SUB 3 - 3 -> aluout = 0, zero = 1.
REQ-036 SLT with 0xFFFFFFFF, 1 -> aluout = 1; SLTU with the same operands -> aluout = 0; NOR 0, 0 -> aluout = 0xFFFFFFFF.
REQ-037 MULTU 0xFFFFFFFF * 2 with start at cycle 0 -> busy in cycles 1..32, done in cycle 33, hi = 1, lo = 0xFFFFFFFE.
REQ-038 DIVU 100 / 7 -> lo = 14, hi = 2; DIVU 9 / 0 -> lo = 0xFFFFFFFF, hi = 9.
REQ-039 Second start in RUN with new operands -> ignored, first result intact; reset at cycle 10 of RUN -> IDLE, hi = lo = 0, no done.
